// File: rtl/sonic_vc_tx_pkg.sv
// Shared types and constants for the SONIC VC TX 128->64 width adapter.
// The buffered-beat record keeps the sink fields exactly as they were captured.
package sonic_vc_tx_pkg;

    localparam int WA_IN_W        = 128;
    localparam int WA_OUT_W       = 64;
    localparam int WA_EMPTY_W     = 2;
    localparam int WA_SRC_EMPTY_W = 1;

    typedef struct packed {
        logic [WA_IN_W-1:0]    data;
        logic                  sop;
        logic                  eop;
        logic [WA_EMPTY_W-1:0] empty;
        logic                  error;
    } wa_beat_t;

    typedef enum logic {
        HALF_HI = 1'b0,
        HALF_LO = 1'b1
    } wa_half_t;

    // An eop beat that has at most two valid words fits entirely in the upper half.
    function automatic logic wa_is_short(input wa_beat_t beat);
        return beat.eop && beat.empty[1];
    endfunction

endpackage

// File: rtl/sonic_vc_tx_wa_buf.sv
// Two-entry FIFO-ordered buffer of captured 128-bit beats.
// A write while full is accepted only when the head retires in the same cycle.
module sonic_vc_tx_wa_buf
    import sonic_vc_tx_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  wa_beat_t   i_wr_beat,
    input  logic       i_retire,
    output wa_beat_t   o_head,
    output logic [1:0] o_count,
    output logic       o_drop
);

    wa_beat_t   r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic w_full;
    logic w_wr;

    assign w_full  = (r_count == 2'd2);
    assign w_wr    = i_wr_en && (!w_full || i_retire);
    assign o_drop  = i_wr_en && w_full && !i_retire;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_beat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_retire) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, i_retire};
        end
    end

endmodule

// File: rtl/sonic_vc_tx_width_adapter.sv
// 128-bit to 64-bit Avalon-ST width adapter for the SONIC VC TX path.
// Optional packet/error statistics are built when SONIC_VC_TX_WA_STATS_EN is defined.
module sonic_vc_tx_width_adapter
    import sonic_vc_tx_pkg::*;
#(
    parameter int IN_W  = 128,
    parameter int OUT_W = 64
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic [IN_W-1:0]   avalonst_sink_data,
    input  logic [1:0]        avalonst_sink_empty,
    input  logic              avalonst_sink_startofpacket,
    input  logic              avalonst_sink_endofpacket,
    input  logic              avalonst_sink_error,
    input  logic              avalonst_sink_valid,
    output logic              avalonst_sink_ready,
    output logic [OUT_W-1:0]  avalonst_source_data,
    output logic              avalonst_source_empty,
    output logic              avalonst_source_startofpacket,
    output logic              avalonst_source_endofpacket,
    output logic              avalonst_source_error,
    output logic              avalonst_source_valid,
    input  logic              avalonst_source_ready,
    output logic [31:0]       stat_pkt_count,
    output logic [31:0]       stat_err_count
);

    wa_half_t   r_half;
    wa_half_t   w_half_next;
    wa_beat_t   w_wr_beat;
    wa_beat_t   w_head;
    logic [1:0] w_count;
    logic       w_drop;
    logic       w_valid;
    logic       w_xfer;
    logic       w_retire;
    logic [2:0] w_next_occ;

    logic [OUT_W-1:0] w_src_data;
    logic             w_src_empty;
    logic             w_src_sop;
    logic             w_src_eop;
    logic             w_src_error;

    // Empty only carries meaning on an eop beat, so it is zeroed at capture.
    always_comb begin
        w_wr_beat       = '0;
        w_wr_beat.data  = avalonst_sink_data;
        w_wr_beat.sop   = avalonst_sink_startofpacket;
        w_wr_beat.eop   = avalonst_sink_endofpacket;
        w_wr_beat.error = avalonst_sink_error;
        w_wr_beat.empty = avalonst_sink_endofpacket ? avalonst_sink_empty : '0;
    end

    sonic_vc_tx_wa_buf u_buf (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_wr_en   (avalonst_sink_valid),
        .i_wr_beat (w_wr_beat),
        .i_retire  (w_retire),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_drop    (w_drop)
    );

    assign w_valid = (w_count != 2'd0);
    assign w_xfer  = w_valid && avalonst_source_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_half <= HALF_HI;
        end else begin
            r_half <= w_half_next;
        end
    end

    always_comb begin
        w_half_next = r_half;
        w_retire    = 1'b0;
        w_src_data  = '0;
        w_src_empty = 1'b0;
        w_src_sop   = 1'b0;
        w_src_eop   = 1'b0;
        w_src_error = 1'b0;
        if (w_valid) begin
            case (r_half)
                HALF_HI: begin
                    w_src_data = w_head.data[WA_IN_W-1 -: WA_OUT_W];
                    w_src_sop  = w_head.sop;
                    if (wa_is_short(w_head)) begin
                        // empty 2/3 becomes 0/1 once the unused lower half is dropped
                        w_src_eop   = 1'b1;
                        w_src_empty = w_head.empty[0];
                        w_src_error = w_head.error;
                        w_retire    = w_xfer;
                    end else if (w_xfer) begin
                        w_half_next = HALF_LO;
                    end
                end
                HALF_LO: begin
                    w_src_data  = w_head.data[WA_OUT_W-1:0];
                    w_src_eop   = w_head.eop;
                    w_src_empty = w_head.eop && w_head.empty[0];
                    w_src_error = w_head.eop && w_head.error;
                    if (w_xfer) begin
                        w_retire    = 1'b1;
                        w_half_next = HALF_HI;
                    end
                end
                default: begin
                    w_half_next = HALF_HI;
                end
            endcase
        end
    end

    assign avalonst_source_valid         = w_valid;
    assign avalonst_source_data          = w_src_data;
    assign avalonst_source_empty         = w_src_empty;
    assign avalonst_source_startofpacket = w_src_sop;
    assign avalonst_source_endofpacket   = w_src_eop;
    assign avalonst_source_error         = w_src_error;

    // Ready promises room for a beat that the FIFO will present one cycle later.
    assign w_next_occ          = {1'b0, w_count} + {2'b00, avalonst_sink_valid} - {2'b00, w_retire};
    assign avalonst_sink_ready = !reset && (w_next_occ <= 3'd1);

`ifdef SONIC_VC_TX_WA_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_err_count;
    logic        w_eop_xfer;

    assign w_eop_xfer = w_xfer && w_src_eop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pkt_count <= '0;
            r_err_count <= '0;
        end else begin
            r_pkt_count <= r_pkt_count + 32'(w_eop_xfer);
            r_err_count <= r_err_count + 32'(w_eop_xfer && w_src_error) + 32'(w_drop);
        end
    end

    assign stat_pkt_count = r_pkt_count;
    assign stat_err_count = r_err_count;
`else
    logic w_unused_drop;
    assign w_unused_drop  = w_drop;
    assign stat_pkt_count = '0;
    assign stat_err_count = '0;
`endif

endmodule

// File: tb/tb_sonic_vc_tx_width_adapter.sv
// Scoreboard bench for the 128->64 TX width adapter: a driver honours ready latency 1,
// a reference model expands each accepted beat into 64-bit beats, and a monitor checks them.
module tb_sonic_vc_tx_width_adapter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] sink_data  = '0;
    logic [1:0]   sink_empty = '0;
    logic         sink_sop   = 1'b0;
    logic         sink_eop   = 1'b0;
    logic         sink_err   = 1'b0;
    logic         sink_valid = 1'b0;
    logic         sink_ready;
    logic [63:0]  src_data;
    logic         src_empty, src_sop, src_eop, src_err, src_valid;
    logic         src_ready = 1'b0;
    logic [31:0]  stat_pkt, stat_err;

    always #5 clock = ~clock;

    sonic_vc_tx_width_adapter dut (
        .clock                         (clock),
        .reset                         (reset),
        .avalonst_sink_data            (sink_data),
        .avalonst_sink_empty           (sink_empty),
        .avalonst_sink_startofpacket   (sink_sop),
        .avalonst_sink_endofpacket     (sink_eop),
        .avalonst_sink_error           (sink_err),
        .avalonst_sink_valid           (sink_valid),
        .avalonst_sink_ready           (sink_ready),
        .avalonst_source_data          (src_data),
        .avalonst_source_empty         (src_empty),
        .avalonst_source_startofpacket (src_sop),
        .avalonst_source_endofpacket   (src_eop),
        .avalonst_source_error         (src_err),
        .avalonst_source_valid         (src_valid),
        .avalonst_source_ready         (src_ready),
        .stat_pkt_count                (stat_pkt),
        .stat_err_count                (stat_err)
    );

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [1:0]   empty;
        logic         err;
    } in_beat_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        empty;
        logic        err;
    } out_beat_t;

    in_beat_t  stim_q[$];
    out_beat_t exp_q[$];
    int        xfer_cyc[$];
    int        checks    = 0;
    int        passes    = 0;
    int        cyc       = 0;
    int        src_mode  = 0;   // 0: always ready, 1: random, 2: stalled
    logic      ready_q   = 1'b0;
    logic      junk_en   = 1'b0;
    logic      hi_seen   = 1'b0;
    int        model_pkt = 0;
    int        model_err = 0;
    int        drive_cyc = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a 128-bit beat holds 4 words; the packet's valid words leave in 64-bit beats.
    function automatic void expand(input in_beat_t b);
        out_beat_t o;
        int        words;
        words = b.eop ? 4 - int'(b.empty) : 4;
        o.data = b.data[127:64];
        o.sop  = b.sop;
        if (words <= 2) begin
            o.eop   = 1'b1;
            o.empty = 1'(2 - words);
            o.err   = b.err;
            exp_q.push_back(o);
        end else begin
            o.eop   = 1'b0;
            o.empty = 1'b0;
            o.err   = 1'b0;
            exp_q.push_back(o);
            o.data  = b.data[63:0];
            o.sop   = 1'b0;
            o.eop   = b.eop;
            o.empty = b.eop ? 1'(4 - words) : 1'b0;
            o.err   = b.eop ? b.err : 1'b0;
            exp_q.push_back(o);
        end
    endfunction

    function automatic in_beat_t mk(input logic [127:0] d, input logic sop, input logic eop,
                                    input logic [1:0] empty, input logic err);
        in_beat_t b;
        b.data = d; b.sop = sop; b.eop = eop; b.empty = empty; b.err = err;
        return b;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Driver: a beat is presented only in the cycle after sink_ready was seen high.
    initial begin
        in_beat_t b;
        forever begin
            @(posedge clock);
            #1;
            src_ready = (src_mode == 0) ? 1'b1 :
                        (src_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
            if (reset) begin
                sink_valid = junk_en;
                sink_data  = rnd128();
                sink_sop   = 1'b1;
                sink_eop   = 1'b1;
                sink_empty = 2'($urandom_range(0, 3));
                sink_err   = 1'b0;
            end else if (ready_q && stim_q.size() > 0) begin
                b          = stim_q.pop_front();
                sink_valid = 1'b1;
                sink_data  = b.data;
                sink_sop   = b.sop;
                sink_eop   = b.eop;
                sink_empty = b.empty;
                sink_err   = b.err;
                drive_cyc  = cyc;
                expand(b);
            end else begin
                sink_valid = 1'b0;
                sink_data  = rnd128();
                sink_sop   = 1'($urandom_range(0, 1));
                sink_eop   = 1'($urandom_range(0, 1));
                sink_empty = 2'($urandom_range(0, 3));
                sink_err   = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    initial begin
        out_beat_t e;
        logic      stall_prev = 1'b0;
        logic [67:0] last_out = '0;
        forever begin
            @(negedge clock);
            ready_q = sink_ready;
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    chk("stall_stable", 128'({src_valid, src_data, src_sop, src_eop, src_empty, src_err}),
                        128'({1'b1, last_out}));
                if (src_valid && src_ready) begin
                    xfer_cyc.push_back(cyc);
                    $display("out cyc=%0d data=%h sop=%0b eop=%0b empty=%0b err=%0b",
                             cyc, src_data, src_sop, src_eop, src_empty, src_err);
                    if (src_sop && !src_eop) hi_seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 128'({src_data, src_sop, src_eop, src_empty, src_err}), '1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", 128'({src_data, src_sop, src_eop, src_empty, src_err}),
                            128'({e.data, e.sop, e.eop, e.empty, e.err}));
                        if (e.eop) model_pkt++;
                        if (e.eop && e.err) model_err++;
                    end
                end
                stall_prev = src_valid && !src_ready;
                last_out   = {src_data, src_sop, src_eop, src_empty, src_err};
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n < 3000) passes++;
        else $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, stim_q.size() + exp_q.size());
        repeat (3) @(negedge clock);
    endtask

    task automatic check_stats(input string name);
`ifdef SONIC_VC_TX_WA_STATS_EN
        chk({name, "_pkt"}, 128'(stat_pkt), 128'(model_pkt));
        chk({name, "_err"}, 128'(stat_err), 128'(model_err));
`else
        chk({name, "_pkt"}, 128'(stat_pkt), 128'(0));
        chk({name, "_err"}, 128'(stat_err), 128'(0));
`endif
    endtask

    initial begin
        int n;
        int len;
        logic [31:0] err_before;
        logic [31:0] pkt_before;

        // Reset with junk beats offered by the FIFO; none may be kept.
        junk_en = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_src_valid", 128'(src_valid), 128'(0));
        chk("rst_sink_ready", 128'(sink_ready), 128'(0));
        chk("rst_src_fields", 128'({src_data, src_sop, src_eop, src_empty, src_err}), 128'(0));
        chk("rst_stats", 128'({stat_pkt, stat_err}), 128'(0));
        junk_en = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle_sink_ready", 128'(sink_ready), 128'(1));

        // Single-beat packet, full 128 bits, plus capture-to-output latency.
        src_mode = 0;
        xfer_cyc.delete();
        stim_q.push_back(mk(128'h0123456789ABCDEF0123456789ABCDEF, 1'b1, 1'b1, 2'd0, 1'b0));
        wait_drain("one_beat");
        chk("one_beat_count", 128'(xfer_cyc.size()), 128'(2));
        n = (xfer_cyc.size() > 0) ? xfer_cyc[0] : 0;
        chk("one_beat_latency", 128'(n - drive_cyc), 128'(1));

        // Short eop (empty=3) followed by a packet that must start in the upper half.
        xfer_cyc.delete();
        stim_q.push_back(mk(rnd128(), 1'b1, 1'b1, 2'd3, 1'b0));
        stim_q.push_back(mk(rnd128(), 1'b1, 1'b1, 2'd1, 1'b0));
        wait_drain("short_eop");
        chk("short_eop_count", 128'(xfer_cyc.size()), 128'(3));

        // Three-beat packet streams six output beats back to back.
        xfer_cyc.delete();
        stim_q.push_back(mk(rnd128(), 1'b1, 1'b0, 2'd2, 1'b0));
        stim_q.push_back(mk(rnd128(), 1'b0, 1'b0, 2'd0, 1'b1));
        stim_q.push_back(mk(rnd128(), 1'b0, 1'b1, 2'd1, 1'b0));
        wait_drain("stream");
        chk("stream_count", 128'(xfer_cyc.size()), 128'(6));
        n = (xfer_cyc.size() == 6) ? xfer_cyc[5] - xfer_cyc[0] : -1;
        chk("stream_span", 128'(n), 128'(5));

        // Output stalled for 10 cycles: the buffer fills to two beats and backpressures.
        src_mode = 2;
        stim_q.push_back(mk(rnd128(), 1'b1, 1'b0, 2'd0, 1'b0));
        stim_q.push_back(mk(rnd128(), 1'b0, 1'b0, 2'd0, 1'b0));
        stim_q.push_back(mk(rnd128(), 1'b0, 1'b0, 2'd0, 1'b0));
        stim_q.push_back(mk(rnd128(), 1'b0, 1'b1, 2'd2, 1'b1));
        repeat (10) @(negedge clock);
        chk("stall_sink_ready", 128'(sink_ready), 128'(0));
        chk("stall_src_valid", 128'(src_valid), 128'(1));
        chk("stall_backlog", 128'(stim_q.size()), 128'(2));
        src_mode = 0;
        wait_drain("stall");

        // Errored eop: error flag on the final beat and both counters advance.
        pkt_before = stat_pkt;
        err_before = stat_err;
        stim_q.push_back(mk(rnd128(), 1'b1, 1'b0, 2'd0, 1'b0));
        stim_q.push_back(mk(rnd128(), 1'b0, 1'b1, 2'd0, 1'b1));
        wait_drain("err_pkt");
`ifdef SONIC_VC_TX_WA_STATS_EN
        chk("err_pkt_pkt_delta", 128'(stat_pkt - pkt_before), 128'(1));
        chk("err_pkt_err_delta", 128'(stat_err - err_before), 128'(1));
`else
        chk("err_pkt_pkt_delta", 128'(stat_pkt - pkt_before), 128'(0));
        chk("err_pkt_err_delta", 128'(stat_err - err_before), 128'(0));
`endif
        check_stats("err_pkt_stats");

        // Reset between the upper and lower half of a packet drops the remainder.
        hi_seen = 1'b0;
        stim_q.push_back(mk(rnd128(), 1'b1, 1'b0, 2'd0, 1'b0));
        stim_q.push_back(mk(rnd128(), 1'b0, 1'b1, 2'd0, 1'b0));
        n = 0;
        while (!hi_seen && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("midpkt_hi_seen", 128'(hi_seen), 128'(1));
        @(posedge clock); #2;
        reset = 1'b1;
        stim_q.delete();
        exp_q.delete();
        model_pkt = 0;
        model_err = 0;
        @(negedge clock);
        chk("midpkt_src_valid", 128'(src_valid), 128'(0));
        chk("midpkt_sink_ready", 128'(sink_ready), 128'(0));
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        chk("midpkt_stats_cleared", 128'({stat_pkt, stat_err}), 128'(0));
        stim_q.push_back(mk(rnd128(), 1'b1, 1'b1, 2'd0, 1'b0));
        wait_drain("after_reset");

        // Randomized packets with random output backpressure.
        src_mode = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++)
                stim_q.push_back(mk(rnd128(), 1'(k == 0), 1'(k == len - 1),
                                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))));
        end
        wait_drain("random");
        src_mode = 0;
        repeat (3) @(negedge clock);
        check_stats("final_stats");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sonic_vc_tx_width_adapter.md
SONIC_VC_TX_WIDTH_ADAPTER -- requirements
Module: sonic_vc_tx_width_adapter

Interface
REQ-001 SHALL have parameter IN_W, default 128, meaning input data width in bits; legal value 128 only.
REQ-002 SHALL have parameter OUT_W, default 64, meaning output data width in bits; legal value 64 only.
REQ-003 SHALL have port clock, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port avalonst_sink_data, input, 128, packet data; bits [127:64] form the first 64-bit half.
REQ-006 SHALL have port avalonst_sink_empty, input, 2, count of unused 32-bit words on an eop beat.
REQ-007 SHALL have ports avalonst_sink_startofpacket, avalonst_sink_endofpacket and avalonst_sink_error, each input, 1, packet framing and error flags.
REQ-008 SHALL have port avalonst_sink_valid, input, 1, beat present; the upstream TX FIFO asserts it one cycle after ready (ready latency 1).
REQ-009 SHALL have port avalonst_sink_ready, output, 1, space-available indication toward the FIFO.
REQ-010 SHALL have ports avalonst_source_data (output, 64) and avalonst_source_empty (output, 1), the output beat and its unused-32-bit-word count.
REQ-011 SHALL have ports avalonst_source_startofpacket, avalonst_source_endofpacket, avalonst_source_error and avalonst_source_valid, each output, 1.
REQ-012 SHALL have port avalonst_source_ready, input, 1; the output handshake is ready latency 0, so a transfer happens when valid and ready are both high.
REQ-013 SHALL have ports stat_pkt_count (output, 32) and stat_err_count (output, 32), see Configuration.

Function
REQ-014 SHALL buffer at most 2 accepted 128-bit beats in a FIFO-ordered buffer; C is the occupancy (0..2).
REQ-015 SHALL capture each beat on which avalonst_sink_valid=1 unconditionally.
REQ-016 SHALL compute avalonst_sink_ready combinationally as (C + sink_valid - retire) <= 1.
  - retire = 1 when the head entry's last half transfers in this cycle.
REQ-017 SHALL hold overflow impossible; an arriving beat while C=2 is an upstream violation, is dropped, and (with stats enabled) increments stat_err_count.
REQ-018 SHALL use a per-head-entry half state, HALF_HI -> HALF_LO -> (retire, back to HALF_HI for the next entry).
REQ-019 SHALL emit in HALF_HI: data[127:64], startofpacket = the entry's sop, endofpacket = 0, empty = 0, error = 0.
REQ-020 SHALL emit in HALF_LO: data[63:0], startofpacket = 0, endofpacket = the entry's eop, empty = entry empty[0] when eop, error = entry error when eop.
REQ-021 SHALL, for an eop entry with empty >= 2 (2 or fewer valid words), skip HALF_LO: emit one beat with eop=1, empty = empty-2 and error; the entry retires after that single transfer.
REQ-022 SHALL treat sink empty as 0 on non-eop beats.
REQ-023 SHALL drive avalonst_source_valid = (C > 0) and combinational outputs from the head entry; outputs stay stable while valid=1 and ready=0.
REQ-024 SHALL allow, in the same cycle as a retire, a new arrival to write the freed or the next slot without loss.
REQ-025 SHALL give latency sink beat to first source beat of 1 cycle when C=0 (registered capture, combinational output).
REQ-026 SHALL sustain throughput of 1 output beat per cycle with source_ready held at 1.

Reset
REQ-027 SHALL, while reset=1, clear C to 0, set the half state to HALF_HI and clear the counters.
REQ-028 SHALL, during reset, drive avalonst_source_valid=0, avalonst_sink_ready=0 and all source fields 0; sink beats arriving during reset are discarded.
REQ-029 SHALL, on a reset mid-packet, drop any partial packet; no eop is synthesized.

Configuration
REQ-030 SHALL, with SONIC_VC_TX_WA_STATS_EN defined, count each output eop transfer in stat_pkt_count and each eop transfer with error=1 or dropped beat in stat_err_count.
  - Both counters are 32-bit and wrap at 2^32-1 -> 0.
REQ-031 SHALL, without SONIC_VC_TX_WA_STATS_EN, drive both counter ports constant 0 and synthesize no counter logic.

Structure
REQ-032 SHALL place width constants, the empty-width constant and the buffered-beat record type (data, sop, eop, empty, error) in shared package sonic_vc_tx_pkg.
REQ-033 SHALL implement the 2-entry beat buffer as sub-module sonic_vc_tx_wa_buf (write, read/retire, count); the half state machine and output mux reside in the top.

Verification
REQ-034 SHALL cover: 1-beat packet, sop=eop=1, empty=0, data=0x0123..EF (128b) -> two beats 0x0123456789ABCDEF (sop) then 0x0123456789ABCDEF lower half (eop, empty=0).
REQ-035 SHALL cover: eop beat with empty=3 -> single beat data[127:64], eop=1, empty=1; next entry starts in HALF_HI.
REQ-036 SHALL cover: 3-beat packet, source_ready=1 constant -> 6 output beats in 6 consecutive cycles, sink_ready toggling so C never exceeds 2.
REQ-037 SHALL cover: source_ready=0 for 10 cycles with a streaming sink -> C saturates at 2, sink_ready=0, outputs stable, no beat lost once ready returns.
REQ-038 SHALL cover: error=1 on an eop beat with stats enabled -> error on the eop output beat; stat_pkt_count and stat_err_count each +1.
REQ-039 SHALL cover: reset asserted between HALF_HI and HALF_LO -> source_valid=0 next cycle; after release the next packet emits sop first.
